// File: rtl/core_pkg.sv
// Shared pipeline types for the 5-stage core: forwarding selects, stage tags
// and the helpers the hazard logic uses to pick an operand source.
package core_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              regwrite;
    logic              isload;
  } stage_tag_t;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  function automatic logic can_forward(input logic              valid,
                                       input logic              regwrite,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] src);
    return valid && regwrite && (rd != '0) && (rd == src);
  endfunction

  function automatic fwd_sel_e fwd_select(input logic m_hit, input logic w_hit);
    if (m_hit) return FWD_MEM;
    if (w_hit) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_stage_tracker.sv
// Shadow copy of the E/M/W stage tags; holds while memory is busy and takes a
// bubble into E when the decode instruction is squashed.
module hazard_stage_tracker
  import core_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic       bubble,
  input  stage_tag_t d_tag,
  output stage_tag_t e_tag,
  output stage_tag_t m_tag,
  output stage_tag_t w_tag
);

  always_ff @(posedge clock) begin
    if (reset) begin
      e_tag <= '0;
      m_tag <= '0;
      w_tag <= '0;
    end else if (!hold) begin
      if (bubble) e_tag <= '0;
      else        e_tag <= d_tag;
      m_tag <= e_tag;
      w_tag <= m_tag;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard controller for the F/D/E/M/W core: stall/flush priority, operand
// forwarding selects, stall-cycle counter and a sticky memory-timeout flag.
module hazard_scheduler #(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iIdValid,
  input  logic [REG_AW-1:0] iIdRs1,
  input  logic [REG_AW-1:0] iIdRs2,
  input  logic              iIdUsesRs1,
  input  logic              iIdUsesRs2,
  input  logic [REG_AW-1:0] iIdRd,
  input  logic              iIdRegWrite,
  input  logic              iIdIsLoad,
  input  logic              iExPCSrc,
  input  logic              iMemBusy,
  output logic              oStallF,
  output logic              oStallD,
  output logic              oStallE,
  output logic              oStallM,
  output logic              oFlushD,
  output logic              oFlushE,
  output logic [1:0]        oFwdA,
  output logic [1:0]        oFwdB,
  output logic [CNT_W-1:0]  oStallCount,
  output logic              oMemTimeout
);
  import core_pkg::*;

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  stage_tag_t    d_tag, e_tag, m_tag, w_tag;
  logic          load_use;
  logic [TW-1:0] busy_run, busy_next;
  logic          unused_tag_bits;

  always_comb begin
    d_tag          = '0;
    d_tag.valid    = iIdValid;
    d_tag.rd       = iIdRd;
    d_tag.rs1      = iIdRs1;
    d_tag.rs2      = iIdRs2;
    d_tag.regwrite = iIdRegWrite;
    d_tag.isload   = iIdIsLoad;
  end

  hazard_stage_tracker u_tracker (
    .clock  (iClk),
    .reset  (iRst),
    .hold   (iMemBusy),
    .bubble (oFlushE),
    .d_tag  (d_tag),
    .e_tag  (e_tag),
    .m_tag  (m_tag),
    .w_tag  (w_tag)
  );

  // Some tag fields only ride along to later stages and are never inspected here.
  assign unused_tag_bits = ^{e_tag, m_tag, w_tag};

  assign load_use = e_tag.valid && e_tag.isload && (e_tag.rd != '0) &&
                    ((iIdUsesRs1 && (iIdRs1 == e_tag.rd)) ||
                     (iIdUsesRs2 && (iIdRs2 == e_tag.rd)));

  // Reset masks everything; a memory freeze defers branch and load-use handling.
  always_comb begin
    oStallF = 1'b0;
    oStallD = 1'b0;
    oStallE = 1'b0;
    oStallM = 1'b0;
    oFlushD = 1'b0;
    oFlushE = 1'b0;
    oFwdA   = FWD_REG;
    oFwdB   = FWD_REG;
    if (!iRst) begin
      if (iMemBusy) begin
        oStallF = 1'b1;
        oStallD = 1'b1;
        oStallE = 1'b1;
        oStallM = 1'b1;
      end else if (iExPCSrc) begin
        oFlushD = 1'b1;
        oFlushE = 1'b1;
      end else if (load_use) begin
        oStallF = 1'b1;
        oStallD = 1'b1;
        oFlushE = 1'b1;
      end
      oFwdA = fwd_select(can_forward(m_tag.valid, m_tag.regwrite, m_tag.rd, e_tag.rs1),
                         can_forward(w_tag.valid, w_tag.regwrite, w_tag.rd, e_tag.rs1));
      oFwdB = fwd_select(can_forward(m_tag.valid, m_tag.regwrite, m_tag.rd, e_tag.rs2),
                         can_forward(w_tag.valid, w_tag.regwrite, w_tag.rd, e_tag.rs2));
    end
  end

  assign busy_next = (busy_run == TW'(MEM_TIMEOUT)) ? busy_run : busy_run + TW'(1);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oStallCount <= '0;
      busy_run    <= '0;
      oMemTimeout <= 1'b0;
    end else begin
      if (oStallF && (oStallCount != '1)) oStallCount <= oStallCount + CNT_W'(1);
      if (iMemBusy) begin
        busy_run <= busy_next;
        if (busy_next == TW'(MEM_TIMEOUT)) oMemTimeout <= 1'b1;
      end else begin
        busy_run <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against an instruction-level model.
module tb_hazard_scheduler;

  localparam int REG_AW      = 5;
  localparam int CNT_W       = 8;
  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iIdValid;
  logic [REG_AW-1:0] iIdRs1, iIdRs2, iIdRd;
  logic              iIdUsesRs1, iIdUsesRs2, iIdRegWrite, iIdIsLoad;
  logic              iExPCSrc, iMemBusy;
  logic              oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE;
  logic [1:0]        oFwdA, oFwdB;
  logic [CNT_W-1:0]  oStallCount;
  logic              oMemTimeout;

  hazard_scheduler #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .iClk(iClk), .iRst(iRst), .iIdValid(iIdValid), .iIdRs1(iIdRs1), .iIdRs2(iIdRs2),
    .iIdUsesRs1(iIdUsesRs1), .iIdUsesRs2(iIdUsesRs2), .iIdRd(iIdRd),
    .iIdRegWrite(iIdRegWrite), .iIdIsLoad(iIdIsLoad), .iExPCSrc(iExPCSrc),
    .iMemBusy(iMemBusy), .oStallF(oStallF), .oStallD(oStallD), .oStallE(oStallE),
    .oStallM(oStallM), .oFlushD(oFlushD), .oFlushE(oFlushE), .oFwdA(oFwdA),
    .oFwdB(oFwdB), .oStallCount(oStallCount), .oMemTimeout(oMemTimeout)
  );

  always #5 iClk = ~iClk;

  // Instruction record in the model; index 0 = E, 1 = M, 2 = W.
  typedef struct {
    bit v;
    int rd;
    int rs1;
    int rs2;
    bit rw;
    bit ld;
  } instr_t;

  instr_t pipe[3];
  int     mCount = 0;
  int     mRun = 0;
  bit     mTimeout = 0;
  int     errors = 0;
  int     checks = 0;
  bit     eStallF, eStallD, eStallE, eStallM, eFlushD, eFlushE;
  int     eFwdA, eFwdB;

  function automatic int fwdFor(input int src);
    if (pipe[1].v && pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == src) return 2;
    if (pipe[2].v && pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == src) return 1;
    return 0;
  endfunction

  task automatic computeExpected();
    bit lu;
    {eStallF, eStallD, eStallE, eStallM, eFlushD, eFlushE} = '0;
    eFwdA = 0;
    eFwdB = 0;
    if (!iRst) begin
      lu = pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
           ((iIdUsesRs1 && int'(iIdRs1) == pipe[0].rd) ||
            (iIdUsesRs2 && int'(iIdRs2) == pipe[0].rd));
      if (iMemBusy) {eStallF, eStallD, eStallE, eStallM} = 4'b1111;
      else if (iExPCSrc) {eFlushD, eFlushE} = 2'b11;
      else if (lu) {eStallF, eStallD, eFlushE} = 3'b111;
      eFwdA = fwdFor(pipe[0].rs1);
      eFwdB = fwdFor(pipe[0].rs2);
    end
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput();
    computeExpected();
    check("stallF", 32'(oStallF), 32'(eStallF));
    check("stallD", 32'(oStallD), 32'(eStallD));
    check("stallE", 32'(oStallE), 32'(eStallE));
    check("stallM", 32'(oStallM), 32'(eStallM));
    check("flushD", 32'(oFlushD), 32'(eFlushD));
    check("flushE", 32'(oFlushE), 32'(eFlushE));
    check("fwdA", 32'(oFwdA), eFwdA);
    check("fwdB", 32'(oFwdB), eFwdB);
    check("stallCount", 32'(oStallCount), mCount);
    check("memTimeout", 32'(oMemTimeout), 32'(mTimeout));
  endtask

  task automatic applyStimulus(input bit v, input int rd, input int rs1, input int rs2,
                               input bit u1, input bit u2, input bit rw, input bit ld);
    iIdValid    = v;
    iIdRd       = REG_AW'(rd);
    iIdRs1      = REG_AW'(rs1);
    iIdRs2      = REG_AW'(rs2);
    iIdUsesRs1  = u1;
    iIdUsesRs2  = u2;
    iIdRegWrite = rw;
    iIdIsLoad   = ld;
  endtask

  task automatic sampleCycle();
    @(negedge iClk);
    checkOutput();
  endtask

  // Moves the model across one rising edge, then lets the DUT take the same edge.
  task automatic advance();
    instr_t d;
    computeExpected();
    if (iRst) begin
      foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0, 0, 0};
      mCount = 0;
      mRun = 0;
      mTimeout = 0;
    end else begin
      if (eStallF && mCount < CNT_MAX) mCount++;
      if (iMemBusy) begin
        if (mRun < MEM_TIMEOUT) mRun++;
        if (mRun == MEM_TIMEOUT) mTimeout = 1;
      end else begin
        mRun = 0;
        d = '{iIdValid, int'(iIdRd), int'(iIdRs1), int'(iIdRs2), iIdRegWrite, iIdIsLoad};
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = eFlushE ? '{0, 0, 0, 0, 0, 0} : d;
      end
    end
    @(posedge iClk);
    #1;
  endtask

  initial begin
    foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0, 0, 0};
    iRst = 1; iMemBusy = 1; iExPCSrc = 1;
    applyStimulus(1, 4, 4, 4, 1, 1, 1, 1);
    @(posedge iClk);
    #1;

    repeat (3) begin
      sampleCycle();
      check("rst_stallF", 32'(oStallF), 0);
      check("rst_stallM", 32'(oStallM), 0);
      check("rst_flushD", 32'(oFlushD), 0);
      check("rst_count", 32'(oStallCount), 0);
      check("rst_timeout", 32'(oMemTimeout), 0);
      advance();
    end
    iRst = 0; iMemBusy = 0; iExPCSrc = 0;

    // Load-use: lw x5 then add x6,x5,x7
    applyStimulus(1, 5, 1, 0, 1, 0, 1, 1);
    sampleCycle(); advance();
    applyStimulus(1, 6, 5, 7, 1, 1, 1, 0);
    sampleCycle();
    check("lu_stallF", 32'(oStallF), 1);
    check("lu_stallD", 32'(oStallD), 1);
    check("lu_flushE", 32'(oFlushE), 1);
    check("lu_stallE", 32'(oStallE), 0);
    advance();
    sampleCycle();
    check("lu_once", 32'(oStallF), 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    sampleCycle();
    check("lu_fwdA_wb", 32'(oFwdA), 1);
    check("lu_count", 32'(oStallCount), 1);
    advance();

    // Double forward: add x3 in W, sub x3 in M
    applyStimulus(1, 3, 1, 2, 1, 1, 1, 0); sampleCycle(); advance();
    applyStimulus(1, 3, 4, 4, 1, 1, 1, 0); sampleCycle(); advance();
    applyStimulus(1, 8, 3, 3, 1, 1, 1, 0); sampleCycle(); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    sampleCycle();
    check("dbl_fwdA", 32'(oFwdA), 2);
    check("dbl_fwdB", 32'(oFwdB), 2);
    advance();

    // Same shape with rd = x0 everywhere
    applyStimulus(1, 0, 1, 2, 1, 1, 1, 0); sampleCycle(); advance();
    applyStimulus(1, 0, 4, 4, 1, 1, 1, 0); sampleCycle(); advance();
    applyStimulus(1, 8, 0, 0, 1, 1, 1, 0); sampleCycle(); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    sampleCycle();
    check("x0_fwdA", 32'(oFwdA), 0);
    check("x0_fwdB", 32'(oFwdB), 0);
    advance();

    // Branch taken while a load-use is pending
    applyStimulus(1, 9, 1, 1, 1, 0, 1, 1); sampleCycle(); advance();
    applyStimulus(1, 10, 2, 9, 0, 1, 1, 0);
    iExPCSrc = 1;
    sampleCycle();
    check("br_flushD", 32'(oFlushD), 1);
    check("br_flushE", 32'(oFlushE), 1);
    check("br_stallF", 32'(oStallF), 0);
    check("br_stallD", 32'(oStallD), 0);
    advance();
    iExPCSrc = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    sampleCycle();
    check("br_count", 32'(oStallCount), 1);
    advance();

    // Memory freeze with a taken branch held underneath
    applyStimulus(1, 11, 9, 9, 1, 1, 1, 0);
    iExPCSrc = 1; iMemBusy = 1;
    repeat (4) begin
      sampleCycle();
      check("frz_stallF", 32'(oStallF), 1);
      check("frz_stallE", 32'(oStallE), 1);
      check("frz_stallM", 32'(oStallM), 1);
      check("frz_flushE", 32'(oFlushE), 0);
      advance();
    end
    iMemBusy = 0;
    sampleCycle();
    check("frz_flushD", 32'(oFlushD), 1);
    check("frz_flushE5", 32'(oFlushE), 1);
    check("frz_count", 32'(oStallCount), 5);
    advance();
    iExPCSrc = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Seven busy cycles must not trip the timeout
    iMemBusy = 1;
    repeat (7) begin sampleCycle(); advance(); end
    iMemBusy = 0;
    repeat (2) begin
      sampleCycle();
      check("to7_timeout", 32'(oMemTimeout), 0);
      advance();
    end

    // Eight busy cycles trip it, and it stays set
    iMemBusy = 1;
    repeat (8) begin sampleCycle(); advance(); end
    iMemBusy = 0;
    repeat (4) begin
      sampleCycle();
      check("to8_timeout", 32'(oMemTimeout), 1);
      advance();
    end

    // Long freeze saturates the stall counter
    iMemBusy = 1;
    repeat (CNT_MAX + 20) begin sampleCycle(); advance(); end
    iMemBusy = 0;
    sampleCycle();
    check("sat_count", 32'(oStallCount), CNT_MAX);
    advance();

    // Reset in the middle of a freeze
    iMemBusy = 1; iExPCSrc = 1; iRst = 1;
    sampleCycle();
    check("midrst_stallF", 32'(oStallF), 0);
    check("midrst_flushD", 32'(oFlushD), 0);
    advance();
    iRst = 0; iMemBusy = 0; iExPCSrc = 0;
    sampleCycle();
    check("midrst_count", 32'(oStallCount), 0);
    check("midrst_timeout", 32'(oMemTimeout), 0);
    advance();

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      iRst     = ($urandom_range(0, 499) == 0);
      iMemBusy = ($urandom_range(0, 3) == 0);
      iExPCSrc = ($urandom_range(0, 7) == 0);
      applyStimulus(bit'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0));
      sampleCycle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
